traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Phase sequencer for the two-road intersection, directly downstream of the 1-second tick generator. Consumes the single-cycle 1-second tick and steps the lights through all-red, green and yellow phases for road A and road B. Each phase holds for a parameterised number of ticks. Also provides a night-mode flashing-yellow override and a two-digit BCD countdown for the seven-segment display stage.

## Interface
- GREEN_S, 25: green duration in ticks (legal 1..99)
- YELLOW_S, 3: yellow duration in ticks (legal 1..99)
- ALLRED_S, 2: all-red clearance duration in ticks (legal 1..99)
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- tick  in  1  1-second tick, single-cycle pulse from the tick generator
- en  in  1  run enable; when low, ticks are ignored and all state is frozen
- night  in  1  night-mode request, level-sensitive, sampled only on accepted ticks
- light_a  out  3  road A lamps {red, yellow, green}, one-hot or all-zero
- light_b  out  3  road B lamps {red, yellow, green}, one-hot or all-zero
- secs_left  out  7  ticks remaining in the current phase, binary
- bcd_tens  out  4  tens digit of secs_left
- bcd_ones  out  4  ones digit of secs_left
- phase  out  3  current state encoding, for debug and monitoring

## Operation
- Accepted tick = tick & en. Nothing changes in any other cycle.
- States: ALLRED_A (both red, before A green), GREEN_A, YELLOW_A, ALLRED_B, GREEN_B, YELLOW_B, FLASH.
- Normal ring: ALLRED_A→GREEN_A→YELLOW_A→ALLRED_B→GREEN_B→YELLOW_B→ALLRED_A.
- Phase entry loads secs_left with that phase's duration.
- Accepted tick with secs_left > 1: decrement secs_left.
- Accepted tick with secs_left == 1: advance to the next state and load its duration. Each phase therefore lasts exactly its duration in ticks, and secs_left never shows 0 in normal mode.
- Lamps by state:
  - GREEN_A: A green, B red. YELLOW_A: A yellow, B red.
  - GREEN_B: B green, A red. YELLOW_B: B yellow, A red.
  - ALLRED_*: both red.
  - FLASH: both yellow when blink=1, all lamps off when blink=0.
- Night entry: accepted tick with night=1 in any normal state → FLASH. secs_left=0, blink=1. Entry is immediate and not deferred to the phase end.
- In FLASH, each accepted tick with night=1 toggles blink.
- Night exit: accepted tick with night=0 in FLASH → ALLRED_A, secs_left=ALLRED_S, blink=0.
- Night has priority over phase expiry on the same tick.
- BCD: tens = secs_left/10, ones = secs_left%10. Combinational from secs_left; range 0..99 guaranteed.
- Illegal phase encoding recovers to ALLRED_A with ALLRED_S on the next clock, without waiting for a tick.

## Timing
- Reset values: state ALLRED_A, secs_left=ALLRED_S, blink=0, light_a=light_b=3'b100, phase=ALLRED_A encoding, BCD matching ALLRED_S.
- Accepted tick in cycle N: state, secs_left and blink update at the clock edge ending cycle N and are visible in cycle N+1. Latency is 1 cycle.
- Lamp, BCD and phase outputs are combinational decodes of registers. They change only on clock edges, with no path from tick, en or night to the outputs.
- Asserting rst_n low mid-phase forces reset values immediately; the first accepted tick after release decrements ALLRED_S.
- en low for any duration: the count and blink are held exactly and resume on the next accepted tick.
- Back-to-back ticks (tick high for consecutive cycles) are each accepted. The block does not rely on tick spacing.

## Structure
- Shared package traffic_pkg holds:
  - the phase enum (7 states, 3-bit);
  - lamp encoding constants (LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000);
  - the 7-bit count width constant.
- One sub-module: traffic_bcd_split, a 7-bit binary to two-digit BCD converter (combinational). The display stage reuses it.
- Elaboration-time check: each duration parameter is in 1..99.

## Test plan
- Reset, then 2 ticks → phase GREEN_A, secs_left=25, bcd 2/5, light_a=001, light_b=100.
- Full cycle with defaults: 60 ticks return to ALLRED_A with secs_left=2. Log the phase sequence and check durations 2/25/3/2/25/3.
- en=0 while tick pulses 5 times during GREEN_A with secs_left=10 → secs_left stays 10. Then en=1 with one tick → 9.
- night=1 on a tick in GREEN_B with secs_left=7 → FLASH with both lamps 010. The next tick gives both 000, the next 010. night=0 then a tick → ALLRED_A, secs_left=2.
- Assert rst_n low mid-YELLOW_A (secs_left=2) → lamps 100/100 and secs_left=2 immediately. After release, one tick → secs_left=1.
- YELLOW_S=1 override: a single tick in YELLOW_A moves to ALLRED_B. Tick on consecutive cycles → each accepted, secs_left decrements twice.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase encoding, lamp codes and countdown width for the intersection controller
package traffic_pkg;
    localparam int CNT_W = 7;
    typedef enum logic [2:0] {
        ALLRED_A = 3'd0,
        GREEN_A  = 3'd1,
        YELLOW_A = 3'd2,
        ALLRED_B = 3'd3,
        GREEN_B  = 3'd4,
        YELLOW_B = 3'd5,
        FLASH    = 3'd6
    } phase_e;
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;
    function automatic phase_e next_phase(phase_e p);
        return (p == YELLOW_B) ? ALLRED_A : phase_e'(p + 3'd1);
    endfunction
endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// traffic_phase_ctrl_if: tick/control inputs and lamp/countdown outputs of the phase sequencer
interface traffic_phase_ctrl_if;
    import traffic_pkg::*;
    logic             tick;
    logic             en;
    logic             night;
    logic [2:0]       light_a;
    logic [2:0]       light_b;
    logic [CNT_W-1:0] secs_left;
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
    logic [2:0]       phase;
    modport master (output tick, en, night,
                    input  light_a, light_b, secs_left, bcd_tens, bcd_ones, phase);
    modport slave  (input  tick, en, night,
                    output light_a, light_b, secs_left, bcd_tens, bcd_ones, phase);
endinterface

// File: rtl/traffic_bcd_split.sv
// traffic_bcd_split: 7-bit binary (0..99) to two BCD digits
module traffic_bcd_split
    import traffic_pkg::*;
(
    input  logic [CNT_W-1:0] bin_i,
    output logic [3:0]       tens_o,
    output logic [3:0]       ones_o
);
    assign tens_o = 4'(bin_i / CNT_W'(10));
    assign ones_o = 4'(bin_i % CNT_W'(10));
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: tick-driven A/B phase ring with night flashing override and BCD countdown
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    traffic_phase_ctrl_if.slave  bus
);
    if (GREEN_S < 1 || GREEN_S > 99 || YELLOW_S < 1 || YELLOW_S > 99 ||
        ALLRED_S < 1 || ALLRED_S > 99) begin : g_bad_dur
        $error("traffic_phase_ctrl: duration parameters must be in 1..99");
    end

    phase_e           state_q, state_d;
    logic [CNT_W-1:0] secs_q, secs_d;
    logic             blink_q, blink_d;
    logic [2:0]       lamp_a, lamp_b;
    logic [3:0]       tens, ones;
    logic             acc;

    function automatic logic [CNT_W-1:0] dur(phase_e p);
        return (p == GREEN_A  || p == GREEN_B)  ? CNT_W'(GREEN_S)  :
               (p == YELLOW_A || p == YELLOW_B) ? CNT_W'(YELLOW_S) :
               (p == FLASH)                     ? '0 : CNT_W'(ALLRED_S);
    endfunction

    assign acc = bus.tick & bus.en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALLRED_A;
            secs_q  <= CNT_W'(ALLRED_S);
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            secs_q  <= secs_d;
            blink_q <= blink_d;
        end
    end

    // illegal encodings recover without waiting for a tick; night beats phase expiry
    always_comb begin
        state_d = state_q;
        secs_d  = secs_q;
        blink_d = blink_q;
        if (state_q > FLASH) begin
            state_d = ALLRED_A;
            secs_d  = CNT_W'(ALLRED_S);
            blink_d = 1'b0;
        end else if (acc) begin
            if (state_q == FLASH) begin
                if (bus.night) begin
                    blink_d = ~blink_q;
                end else begin
                    state_d = ALLRED_A;
                    secs_d  = CNT_W'(ALLRED_S);
                    blink_d = 1'b0;
                end
            end else if (bus.night) begin
                state_d = FLASH;
                secs_d  = '0;
                blink_d = 1'b1;
            end else if (secs_q > CNT_W'(1)) begin
                secs_d = secs_q - CNT_W'(1);
            end else begin
                state_d = next_phase(state_q);
                secs_d  = dur(state_d);
            end
        end
    end

    always_comb begin
        lamp_a = LAMP_RED;
        lamp_b = LAMP_RED;
        case (state_q)
            GREEN_A:  lamp_a = LAMP_GRN;
            YELLOW_A: lamp_a = LAMP_YEL;
            GREEN_B:  lamp_b = LAMP_GRN;
            YELLOW_B: lamp_b = LAMP_YEL;
            FLASH: begin
                lamp_a = blink_q ? LAMP_YEL : LAMP_OFF;
                lamp_b = blink_q ? LAMP_YEL : LAMP_OFF;
            end
            default: ;
        endcase
    end

    traffic_bcd_split u_bcd (
        .bin_i  (secs_q),
        .tens_o (tens),
        .ones_o (ones)
    );

    assign bus.light_a   = lamp_a;
    assign bus.light_b   = lamp_b;
    assign bus.secs_left = secs_q;
    assign bus.bcd_tens  = tens;
    assign bus.bcd_ones  = ones;
    assign bus.phase     = state_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: scoreboarded check of the phase ring, enable hold, night mode and reset
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;
    localparam int G = 25, Y = 3, R = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    traffic_phase_ctrl_if ifa ();
    traffic_phase_ctrl_if ifb ();

    traffic_phase_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
    traffic_phase_ctrl #(.YELLOW_S(1)) dut_y1 (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        int ph;
        int secs;
        int la;
        int lb;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   m_ph, m_secs;
    bit   m_blink;
    int   cnt[8];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dur(int p);
        return (p == 1 || p == 4) ? G : (p == 2 || p == 5) ? Y : (p == 6) ? 0 : R;
    endfunction

    // lamp codes: 4=red, 2=yellow, 1=green, 0=off
    function automatic int lamp(int p, bit b, bit road_b);
        if (p == 6) return b ? 2 : 0;
        if (!road_b) return (p == 1) ? 1 : (p == 2) ? 2 : 4;
        return (p == 4) ? 1 : (p == 5) ? 2 : 4;
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_secs = R;
        m_blink = 0;
    endtask

    task automatic model_tick(bit n);
        if (m_ph == 6) begin
            if (n) m_blink = !m_blink;
            else begin
                m_ph = 0;
                m_secs = R;
                m_blink = 0;
            end
        end else if (n) begin
            m_ph = 6;
            m_secs = 0;
            m_blink = 1;
        end else if (m_secs > 1) m_secs--;
        else begin
            m_ph = (m_ph + 1) % 6;
            m_secs = dur(m_ph);
        end
    endtask

    task automatic push();
        sb.push_back('{m_ph, m_secs, lamp(m_ph, m_blink, 0), lamp(m_ph, m_blink, 1)});
    endtask

    task automatic pop_check(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, " sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, " phase"}, 32'(ifa.phase), e.ph);
        chk({tag, " secs"}, 32'(ifa.secs_left), e.secs);
        chk({tag, " tens"}, 32'(ifa.bcd_tens), e.secs / 10);
        chk({tag, " ones"}, 32'(ifa.bcd_ones), e.secs % 10);
        chk({tag, " light_a"}, 32'(ifa.light_a), e.la);
        chk({tag, " light_b"}, 32'(ifa.light_b), e.lb);
    endtask

    task automatic step(bit t, bit e, bit n, string tag);
        ifa.tick = t;
        ifa.en = e;
        ifa.night = n;
        if (t && e) model_tick(n);
        push();
        @(negedge clk);
        ifa.tick = 1'b0;
        pop_check(tag);
    endtask

    task automatic run(int n, string tag);
        for (int i = 0; i < n; i++) step(1, 1, 0, tag);
    endtask

    task automatic tick_b(int n);
        ifb.tick = 1'b1;
        repeat (n) @(negedge clk);
        ifb.tick = 1'b0;
    endtask

    initial begin
        ifa.tick = 0; ifa.en = 1; ifa.night = 0;
        ifb.tick = 0; ifb.en = 1; ifb.night = 0;
        model_reset();
        repeat (3) @(negedge clk);
        push();
        pop_check("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        push();
        pop_check("post_reset");

        for (int i = 0; i < 60; i++) begin
            cnt[ifa.phase]++;
            step(1, 1, 0, "ring");
            if (i == 1) begin
                chk("ga phase", 32'(ifa.phase), 1);
                chk("ga secs", 32'(ifa.secs_left), 25);
                chk("ga bcd", {24'd0, ifa.bcd_tens, ifa.bcd_ones}, 32'h25);
                chk("ga lamps", {26'd0, ifa.light_a, ifa.light_b}, 32'b001_100);
            end
        end
        chk("ring end phase", 32'(ifa.phase), 0);
        chk("ring end secs", 32'(ifa.secs_left), 2);
        for (int p = 0; p < 6; p++) chk($sformatf("dur phase%0d", p), cnt[p], dur(p));

        run(17, "to_ga10");
        chk("ga10 secs", 32'(ifa.secs_left), 10);
        repeat (5) step(1, 0, 0, "en_low");
        chk("en_low hold", 32'(ifa.secs_left), 10);
        step(1, 1, 0, "en_resume");
        chk("en_resume secs", 32'(ifa.secs_left), 9);

        run(32, "to_gb7");
        chk("gb7 phase", 32'(ifa.phase), 4);
        chk("gb7 secs", 32'(ifa.secs_left), 7);
        step(1, 1, 1, "night_in");
        chk("flash on", {26'd0, ifa.light_a, ifa.light_b}, 32'b010_010);
        step(1, 1, 1, "blink0");
        chk("flash off", {26'd0, ifa.light_a, ifa.light_b}, 32'b000_000);
        step(0, 1, 1, "no_tick");
        step(1, 1, 1, "blink1");
        chk("flash on2", {26'd0, ifa.light_a, ifa.light_b}, 32'b010_010);
        step(1, 1, 0, "night_out");
        chk("night exit", {24'd0, 1'b0, ifa.phase, 4'(ifa.secs_left)}, 32'h02);

        run(28, "to_ya2");
        chk("ya2 phase", 32'(ifa.phase), 2);
        chk("ya2 secs", 32'(ifa.secs_left), 2);
        rst_n = 1'b0;
        #1;
        model_reset();
        push();
        pop_check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 1, 0, "after_rst");
        chk("after_rst secs", 32'(ifa.secs_left), 1);

        tick_b(27);
        chk("y1 phase", 32'(ifb.phase), 2);
        chk("y1 secs", 32'(ifb.secs_left), 1);
        chk("y1 light_a", 32'(ifb.light_a), 2);
        tick_b(1);
        chk("y1 next phase", 32'(ifb.phase), 3);
        chk("y1 next secs", 32'(ifb.secs_left), 2);
        tick_b(2);
        chk("y1 gb phase", 32'(ifb.phase), 4);
        tick_b(2);
        chk("b2b secs", 32'(ifb.secs_left), 23);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
